// File: rtl/f_issue_if.sv
// Operand/result streams and core-side signals for the f_issue sequencer.
// The slave modport is the f_issue view; master is the environment (producer, consumer, core).
interface f_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             f_start;
    logic [WIDTH-1:0] f_a;
    logic [WIDTH-1:0] f_b;
    logic [WIDTH-1:0] f_result;
    logic             f_done;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, f_result, f_done,
        output in_ready, out_valid, out_data, f_start, f_a, f_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, f_result, f_done,
        input  in_ready, out_valid, out_data, f_start, f_a, f_b
    );
endinterface

// File: rtl/f_issue.sv
// Operand sequencer for the f core: FIFO-buffered (a,b) pairs, one-cycle start,
// done clear-then-set tracking, held result output and a timeout watchdog.
module f_issue #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    f_issue_if.slave    bus,
    output logic        busy,
    output logic        err,
    output logic [15:0] op_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_CLR = 2'd1;
    localparam logic [1:0] WAIT_SET = 2'd2;
    localparam logic [1:0] OUT      = 2'd3;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       state;
    logic [TW-1:0]    timer;
    logic             push, pop, expired;

    assign bus.in_ready = (count != (AW+1)'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == IDLE) && (count != '0);
    assign expired      = (timer == TW'(TIMEOUT - 1));
    assign busy         = (state != IDLE) || (count != '0);

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            bus.f_start   <= 1'b0;
            bus.f_a       <= '0;
            bus.f_b       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            err           <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    bus.f_a     <= mem_a[rd_ptr];
                    bus.f_b     <= mem_b[rd_ptr];
                    bus.f_start <= 1'b1;
                    timer       <= '0;
                    state       <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    bus.f_start <= 1'b0;
                    timer       <= timer + 1'b1;
                    // Only a clean 0 counts as the core acknowledging; X after reset waits.
                    if (bus.f_done == 1'b0) begin
                        state <= WAIT_SET;
                    end else if (expired) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WAIT_SET: begin
                    timer <= timer + 1'b1;
                    if (bus.f_done == 1'b1) begin
                        bus.out_data  <= bus.f_result;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end else if (expired) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    op_count      <= op_count + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
